// File: rtl/team_00_wb_arbiter.sv
// Two-manager Wishbone arbiter in front of a single subordinate (SRAM wrapper).
// Alternates priority on ties, holds a grant for the whole cycle, and aborts stalled strobes.
module team_00_wb_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic       last_grant, last_grant_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       own0, own1, owned;
   logic       fwd_cyc, fwd_stb, timeout;

   always_comb begin
      own0    = (state == GRANT0);
      own1    = (state == GRANT1);
      owned   = own0 | own1;
      fwd_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
      fwd_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
      // A stalled strobe is aborted in the same cycle the limit is reached.
      timeout = fwd_stb & ~s_ack_i & (wait_cnt == TIMEOUT - 8'd1);
   end

   always_comb begin
      s_cyc_o  = fwd_cyc & ~timeout;
      s_stb_o  = fwd_stb & ~timeout;
      s_we_o   = (own0 & m0_we_i) | (own1 & m1_we_i);
      s_sel_o  = own0 ? m0_sel_i : (own1 ? m1_sel_i : 4'h0);
      s_adr_o  = own0 ? m0_adr_i : (own1 ? m1_adr_i : 32'h0);
      s_dat_o  = own0 ? m0_dat_i : (own1 ? m1_dat_i : 32'h0);
      m0_ack_o = own0 & s_ack_i & ~timeout;
      m1_ack_o = own1 & s_ack_i & ~timeout;
      m0_err_o = own0 & timeout;
      m1_err_o = own1 & timeout;
      m0_dat_o = own0 ? s_dat_i : 32'h0;
      m1_dat_o = own1 ? s_dat_i : 32'h0;
      grant_o  = {own1, own0};
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wait_cnt_nxt   = wait_cnt;
      case (state)
         IDLE: begin
            wait_cnt_nxt = 8'd0;
            if (m0_cyc_i && m1_cyc_i) begin
               // Tie goes to whichever manager was not served last.
               state_nxt      = last_grant ? GRANT0 : GRANT1;
               last_grant_nxt = ~last_grant;
            end else if (m0_cyc_i) begin
               state_nxt      = GRANT0;
               last_grant_nxt = 1'b0;
            end else if (m1_cyc_i) begin
               state_nxt      = GRANT1;
               last_grant_nxt = 1'b1;
            end
         end
         GRANT0, GRANT1: begin
            if (!fwd_cyc || timeout) begin
               state_nxt = IDLE;
            end else if (s_ack_i) begin
               wait_cnt_nxt = 8'd0;
            end else if (fwd_stb) begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wait_cnt   <= 8'd0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wait_cnt   <= wait_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_team_00_wb_arbiter.sv
// Bench for team_00_wb_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_team_00_wb_arbiter;

   localparam int TO = 4;

   logic        wb_clk_i, wb_rst_i;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m0_sel_i, m1_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o, s_dat_i;
   logic [1:0]  grant_o;

   int checks = 0;
   int errs   = 0;

   // Reference model: current owner (0 none, 1 = m0, 2 = m1), manager served most
   // recently (1/2), and number of unacknowledged strobe cycles in the current grant.
   int owner  = 0;
   int served = 2;
   int waits  = 0;

   team_00_wb_arbiter #(.TIMEOUT(8'd4)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_timeout();
      bit stb;
      stb = (owner == 1) ? m0_stb_i : (owner == 2) ? m1_stb_i : 1'b0;
      return stb && !s_ack_i && (waits == TO - 1);
   endfunction

   task automatic settle_check();
      logic [1:0]  e_g;
      logic        e_cyc, e_stb, e_we, e_a0, e_a1, e_e0, e_e1, to;
      logic [3:0]  e_sel;
      logic [31:0] e_adr, e_sd, e_d0, e_d1;
      #1;
      e_g = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_adr = 0; e_sd = 0;
      e_a0 = 0; e_a1 = 0; e_e0 = 0; e_e1 = 0; e_d0 = 0; e_d1 = 0;
      to = model_timeout();
      if (owner == 1) begin
         e_g = 2'b01; e_cyc = m0_cyc_i && !to; e_stb = m0_stb_i && !to; e_we = m0_we_i;
         e_sel = m0_sel_i; e_adr = m0_adr_i; e_sd = m0_dat_i;
         e_a0 = s_ack_i && !to; e_e0 = to; e_d0 = s_dat_i;
      end else if (owner == 2) begin
         e_g = 2'b10; e_cyc = m1_cyc_i && !to; e_stb = m1_stb_i && !to; e_we = m1_we_i;
         e_sel = m1_sel_i; e_adr = m1_adr_i; e_sd = m1_dat_i;
         e_a1 = s_ack_i && !to; e_e1 = to; e_d1 = s_dat_i;
      end
      chk("grant", 32'(grant_o), 32'(e_g));
      chk("s_cyc", 32'(s_cyc_o), 32'(e_cyc));
      chk("s_stb", 32'(s_stb_o), 32'(e_stb));
      chk("s_we", 32'(s_we_o), 32'(e_we));
      chk("s_sel", 32'(s_sel_o), 32'(e_sel));
      chk("s_adr", s_adr_o, e_adr);
      chk("s_dat", s_dat_o, e_sd);
      chk("m0_ack", 32'(m0_ack_o), 32'(e_a0));
      chk("m1_ack", 32'(m1_ack_o), 32'(e_a1));
      chk("m0_err", 32'(m0_err_o), 32'(e_e0));
      chk("m1_err", 32'(m1_err_o), 32'(e_e1));
      chk("m0_dat", m0_dat_o, e_d0);
      chk("m1_dat", m1_dat_o, e_d1);
   endtask

   task automatic model_step();
      bit to, cyc;
      to = model_timeout();
      if (wb_rst_i) begin
         owner = 0; served = 2; waits = 0;
      end else if (owner == 0) begin
         waits = 0;
         if (m0_cyc_i && m1_cyc_i) owner = (served == 1) ? 2 : 1;
         else if (m0_cyc_i)        owner = 1;
         else if (m1_cyc_i)        owner = 2;
         if (owner != 0) served = owner;
      end else begin
         cyc = (owner == 1) ? m0_cyc_i : m1_cyc_i;
         if (!cyc || to) owner = 0;
         else if (s_ack_i) waits = 0;
         else if ((owner == 1) ? m0_stb_i : m1_stb_i) waits++;
      end
   endtask

   task automatic advance();
      @(posedge wb_clk_i);
      model_step();
      @(negedge wb_clk_i);
   endtask

   task automatic clear_inputs();
      m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
      m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
      s_ack_i = 0; s_dat_i = 0;
   endtask

   task automatic do_reset();
      wb_rst_i = 1;
      clear_inputs();
      settle_check();
      advance();
      wb_rst_i = 0;
   endtask

   initial begin
      wb_rst_i = 1;
      clear_inputs();
      @(negedge wb_clk_i);
      advance();
      wb_rst_i = 0;
      settle_check();
      chk("reset_grant", 32'(grant_o), 32'h0);
      chk("reset_s_cyc", 32'(s_cyc_o), 32'h0);

      // m0 single write, subordinate acks one cycle after strobe
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
      m0_adr_i = 32'h4; m0_dat_i = 32'h12345678;
      settle_check(); chk("wr_idle_grant", 32'(grant_o), 32'h0); advance();
      settle_check(); chk("wr_grant", 32'(grant_o), 32'h1);
      chk("wr_adr", s_adr_o, 32'h4); chk("wr_dat", s_dat_o, 32'h12345678);
      chk("wr_ack_early", 32'(m0_ack_o), 32'h0); advance();
      s_ack_i = 1;
      settle_check(); chk("wr_ack", 32'(m0_ack_o), 32'h1); advance();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      settle_check(); chk("wr_ack_once", 32'(m0_ack_o), 32'h0); advance();
      settle_check(); chk("wr_release", 32'(grant_o), 32'h0); advance();

      // simultaneous requests after reset: m0 first, then one IDLE cycle, then m1
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      settle_check(); advance();
      s_ack_i = 1;
      settle_check(); chk("tie_first", 32'(grant_o), 32'h1); advance();
      s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
      settle_check(); chk("tie_hold", 32'(grant_o), 32'h1); advance();
      settle_check(); chk("tie_gap", 32'(grant_o), 32'h0); advance();
      settle_check(); chk("tie_second", 32'(grant_o), 32'h2); advance();
      m1_cyc_i = 0; m1_stb_i = 0;
      settle_check(); advance();

      // both managers keep requesting one-beat transfers: grants alternate
      do_reset();
      for (int i = 0; i < 13; i++) begin
         logic [1:0] c, eg;
         int j, b;
         j = (i - 1) % 3; b = ((i - 1) / 3) % 2;
         c = 2'b11; s_ack_i = 0; eg = 2'b00;
         if (i > 0 && j == 0) begin s_ack_i = 1; eg = b ? 2'b10 : 2'b01; end
         if (i > 0 && j == 1) begin c = b ? 2'b01 : 2'b10; eg = b ? 2'b10 : 2'b01; end
         m0_cyc_i = c[0]; m0_stb_i = c[0]; m1_cyc_i = c[1]; m1_stb_i = c[1];
         settle_check(); chk($sformatf("alt_grant_%0d", i), 32'(grant_o), 32'(eg));
         advance();
      end

      // m1 read that is never acknowledged times out on the 4th strobe cycle
      do_reset();
      m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h100;
      settle_check(); advance();
      for (int i = 1; i <= 4; i++) begin
         settle_check();
         chk($sformatf("to_err_%0d", i), 32'(m1_err_o), (i == 4) ? 32'h1 : 32'h0);
         chk($sformatf("to_cyc_%0d", i), 32'(s_cyc_o), (i == 4) ? 32'h0 : 32'h1);
         chk($sformatf("to_m0err_%0d", i), 32'(m0_err_o), 32'h0);
         advance();
      end
      settle_check(); chk("to_idle", 32'(grant_o), 32'h0);
      m1_cyc_i = 0; m1_stb_i = 0; advance();

      // m1 read data routing
      do_reset();
      m1_cyc_i = 1; m1_stb_i = 1;
      settle_check(); advance();
      s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
      settle_check();
      chk("rd_m1_dat", m1_dat_o, 32'hDEADBEEF); chk("rd_m0_dat", m0_dat_o, 32'h0);
      chk("rd_m0_ack", 32'(m0_ack_o), 32'h0); chk("rd_m1_ack", 32'(m1_ack_o), 32'h1);
      advance();
      s_ack_i = 0; s_dat_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
      settle_check(); advance();

      // reset in the middle of an m0 transfer
      do_reset();
      m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h80; m0_dat_i = 32'hA5A5A5A5; m0_sel_i = 4'h3;
      settle_check(); advance();
      settle_check(); chk("mid_grant", 32'(grant_o), 32'h1);
      wb_rst_i = 1;
      settle_check(); advance();
      wb_rst_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
      settle_check();
      chk("rst_grant", 32'(grant_o), 32'h0); chk("rst_cyc", 32'(s_cyc_o), 32'h0);
      chk("rst_adr", s_adr_o, 32'h0); chk("rst_sel", 32'(s_sel_o), 32'h0);
      advance();
      settle_check(); chk("rst_tie_m0", 32'(grant_o), 32'h1); advance();

      // random traffic against the model
      for (int n = 0; n < 800; n++) begin
         wb_rst_i = ($urandom_range(99) == 0);
         if ($urandom_range(3) == 0) m0_cyc_i = ~m0_cyc_i;
         if ($urandom_range(3) == 0) m1_cyc_i = ~m1_cyc_i;
         m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
         m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
         m0_we_i = 1'($urandom_range(1)); m1_we_i = 1'($urandom_range(1));
         m0_sel_i = 4'($urandom_range(15)); m1_sel_i = 4'($urandom_range(15));
         m0_adr_i = $urandom; m1_adr_i = $urandom; m0_dat_i = $urandom; m1_dat_i = $urandom;
         s_ack_i = ($urandom_range(9) < 3);
         s_dat_i = $urandom;
         settle_check();
         advance();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
